// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer.
// Contents: fetch FSM state enum, address/instruction width, default reset PC.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bus bundle between the fetch sequencer, instruction memory and decode.
// Memory side : mem_req, mem_addr (to memory), mem_ack, mem_rdata (from memory)
// Decode side : inst_valid, inst, inst_pc (to decode), inst_ready (from decode)
// master = fetch_ctrl, slave = memory/decode environment.
interface fetch_ctrl_if;
  import fetch_pkg::*;

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;

  modport master (
    output mem_req, mem_addr, inst_valid, inst, inst_pc,
    input  mem_ack, mem_rdata, inst_ready
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst, inst_pc,
    output mem_ack, mem_rdata, inst_ready
  );

endinterface

// File: rtl/fetch_out_reg.sv
// Single-entry valid/ready output slot holding the fetched instruction.
// Ports:
//   clk, rst        : clock, async active-high reset
//   load            : capture load_inst/load_pc and mark valid
//   load_inst/pc    : incoming instruction word and its fetch address
//   flush           : drop the held word (wins over load)
//   ready           : downstream consumes the word when valid & ready
//   valid, inst, pc : registered slot contents
module fetch_out_reg
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] load_inst,
  input  logic [XLEN-1:0] load_pc,
  input  logic            flush,
  input  logic            ready,
  output logic            valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      inst  <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= load_inst;
      pc    <= load_pc;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues req/ack fetches to instruction memory
// and presents fetched words to decode through a one-entry valid/ready slot.
// Ports:
//   clk, rst         : clock, async active-high reset
//   en               : fetch enable (in-flight request still completes)
//   redirect_valid   : single-cycle pulse loading redirect_addr into the PC
//   redirect_addr    : redirect target
//   bus              : fetch_ctrl_if.master (memory + decode handshakes)
//   perf_fetch_cnt   : [FETCH_CTRL_PERF_EN] delivered fetches
//   perf_stall_cnt   : [FETCH_CTRL_PERF_EN] cycles with inst_valid & ~inst_ready
// Optional build macro: FETCH_CTRL_PERF_EN adds the two performance counters.
//
// state | meaning
// IDLE  | no request outstanding; waits for en and a free output slot
// REQ   | request at pc outstanding; ack data goes to the output slot
// DROP  | request at a pre-redirect address outstanding; ack data discarded
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] PC_STEP  = 32'd4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  fetch_ctrl_if.master    bus
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [XLEN-1:0] perf_fetch_cnt,
  output logic [XLEN-1:0] perf_stall_cnt
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] drop_addr_q, drop_addr_d;
  logic            load;
  logic            flush;
  logic            slot_free;
  logic            out_valid;
  logic [XLEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;

  // Slot is free if empty or its word is being consumed this cycle.
  assign slot_free = ~out_valid | bus.inst_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    load        = 1'b0;
    flush       = 1'b0;

    if (redirect_valid) begin
      flush = 1'b1;
      pc_d  = redirect_addr;
      unique case (state_q)
        REQ: begin
          if (bus.mem_ack) begin
            state_d = en ? REQ : IDLE;
          end else begin
            // Request cannot be withdrawn: keep it up at the old address.
            state_d     = DROP;
            drop_addr_d = pc_q;
          end
        end
        DROP: begin
          if (bus.mem_ack) state_d = en ? REQ : IDLE;
        end
        default: state_d = en ? REQ : IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          if (en && slot_free) state_d = REQ;
        end
        REQ: begin
          if (bus.mem_ack) begin
            load = 1'b1;
            pc_d = pc_q + PC_STEP;
            // The new word occupies the slot next cycle; keep fetching only
            // while decode is accepting. Decode is expected not to drop
            // inst_ready while a word is held and a request is outstanding.
            state_d = (en && bus.inst_ready) ? REQ : IDLE;
          end
        end
        DROP: begin
          if (bus.mem_ack) state_d = en ? REQ : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Decoded from registered state only.
  assign bus.mem_req  = (state_q != IDLE);
  assign bus.mem_addr = (state_q == DROP) ? drop_addr_q : pc_q;

  fetch_out_reg u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_inst (bus.mem_rdata),
    .load_pc   (pc_q),
    .flush     (flush),
    .ready     (bus.inst_ready),
    .valid     (out_valid),
    .inst      (out_inst),
    .pc        (out_pc)
  );

  assign bus.inst_valid = out_valid;
  assign bus.inst       = out_inst;
  assign bus.inst_pc    = out_pc;

`ifdef FETCH_CTRL_PERF_EN
  logic [XLEN-1:0] fetch_cnt_q;
  logic [XLEN-1:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (load) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (out_valid && !bus.inst_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl. A second instance covers PC
// wraparound with a non-zero reset PC.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, en2;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        ack_en;
  logic        ready;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  fetch_ctrl_if bus ();
  fetch_ctrl_if bus2 ();

  assign bus.mem_ack    = ack_en & bus.mem_req;
  assign bus.mem_rdata  = inst_of(bus.mem_addr);
  assign bus.inst_ready = ready;

  assign bus2.mem_ack    = bus2.mem_req;
  assign bus2.mem_rdata  = inst_of(bus2.mem_addr);
  assign bus2.inst_ready = 1'b1;

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] pf1, ps1, pf2, ps2;
`endif

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .bus            (bus)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_fetch_cnt (pf1),
    .perf_stall_cnt (ps1)
`endif
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .en             (en2),
    .redirect_valid (1'b0),
    .redirect_addr  (32'h0),
    .bus            (bus2)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_fetch_cnt (pf2),
    .perf_stall_cnt (ps2)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    en             = 1'b0;
    en2            = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 32'h0;
    ack_en         = 1'b1;
    ready          = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset();
    check_val("rst_req",   32'(bus.mem_req), 32'd0);
    check_val("rst_addr",  bus.mem_addr, 32'h0);
    check_val("rst_valid", 32'(bus.inst_valid), 32'd0);
    check_val("rst_inst",  bus.inst, 32'h0);
    check_val("rst_pc",    bus.inst_pc, 32'h0);
    check_val("rst_addr2", bus2.mem_addr, 32'hFFFF_FFF8);

    // streaming at one per cycle
    en = 1'b1;
    tick();
    check_val("t1_req",  32'(bus.mem_req), 32'd1);
    check_val("t1_addr", bus.mem_addr, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val("t1_valid", 32'(bus.inst_valid), 32'd1);
      check_val("t1_pc",    bus.inst_pc, 32'(k * 4));
      check_val("t1_inst",  bus.inst, inst_of(32'(k * 4)));
    end

    // backpressure: one word held, fetching paused
    do_reset();
    ready = 1'b0;
    en    = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      check_val("t2_valid", 32'(bus.inst_valid), 32'd1);
      check_val("t2_pc",    bus.inst_pc, 32'h0);
      check_val("t2_inst",  bus.inst, inst_of(32'h0));
      check_val("t2_noreq", 32'(bus.mem_req), 32'd0);
      if (k < 4) tick();
    end
    ready = 1'b1;
    tick();
    check_val("t2_resume_req",  32'(bus.mem_req), 32'd1);
    check_val("t2_resume_addr", bus.mem_addr, 32'h4);
    check_val("t2_consumed",    32'(bus.inst_valid), 32'd0);
`ifdef FETCH_CTRL_PERF_EN
    check_val("t2_stall_cnt", ps1, 32'd4);
`endif
    tick();
    check_val("t2_pc4", bus.inst_pc, 32'h4);

    // delayed ack at address 8
    do_reset();
    en = 1'b1;
    tick();
    tick();
    tick();
    ack_en = 1'b0;
    check_val("t3_addr_c1", bus.mem_addr, 32'h8);
    tick();
    check_val("t3_addr_c2", bus.mem_addr, 32'h8);
    check_val("t3_empty",   32'(bus.inst_valid), 32'd0);
    tick();
    check_val("t3_addr_c3", bus.mem_addr, 32'h8);
    check_val("t3_req_c3",  32'(bus.mem_req), 32'd1);
    ack_en = 1'b1;
    tick();
    check_val("t3_valid", 32'(bus.inst_valid), 32'd1);
    check_val("t3_pc",    bus.inst_pc, 32'h8);
    check_val("t3_inst",  bus.inst, inst_of(32'h8));

    // redirect during un-acked request at 8
    do_reset();
    en = 1'b1;
    tick();
    tick();
    tick();
    ack_en         = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr  = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check_val("t4_hold_req",  32'(bus.mem_req), 32'd1);
    check_val("t4_hold_addr", bus.mem_addr, 32'h8);
    check_val("t4_flushed",   32'(bus.inst_valid), 32'd0);
    tick();
    check_val("t4_hold_addr2", bus.mem_addr, 32'h8);
    ack_en = 1'b1;
    tick();
    check_val("t4_dropped", 32'(bus.inst_valid), 32'd0);
    check_val("t4_newaddr", bus.mem_addr, 32'h100);
    check_val("t4_newreq",  32'(bus.mem_req), 32'd1);
    tick();
    check_val("t4_valid", 32'(bus.inst_valid), 32'd1);
    check_val("t4_pc",    bus.inst_pc, 32'h100);
    check_val("t4_inst",  bus.inst, inst_of(32'h100));

    // redirect coincident with ack at 12
    do_reset();
    en = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check_val("t5_addr12", bus.mem_addr, 32'hC);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check_val("t5_flushed", 32'(bus.inst_valid), 32'd0);
    check_val("t5_addr",    bus.mem_addr, 32'h40);
    check_val("t5_req",     32'(bus.mem_req), 32'd1);
    tick();
    check_val("t5_pc", bus.inst_pc, 32'h40);

    // reset mid-transaction drops the request at once
    rst = 1'b1;
    #1;
    check_val("rst_mid_req",   32'(bus.mem_req), 32'd0);
    check_val("rst_mid_valid", 32'(bus.inst_valid), 32'd0);

    // wraparound on the second instance
    do_reset();
    en2 = 1'b1;
    tick();
    check_val("t6_addr", bus2.mem_addr, 32'hFFFF_FFF8);
    tick();
    check_val("t6_pc0", bus2.inst_pc, 32'hFFFF_FFF8);
    tick();
    check_val("t6_pc1", bus2.inst_pc, 32'hFFFF_FFFC);
    tick();
    check_val("t6_pc2",   bus2.inst_pc, 32'h0000_0000);
    check_val("t6_inst2", bus2.inst, inst_of(32'h0));
`ifdef FETCH_CTRL_PERF_EN
    check_val("t6_fetch_cnt", pf2, 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
